frame_write_arbiter: RTL
========================

FRAME_WRITE_ARBITER -- requirements
Module: frame_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of pixel-write requesters.
REQ-002 SHALL have parameter ADDR_W, default 19: frame RAM address width (640x480).
REQ-003 SHALL have parameter MAX_WRITES, default 1024: write budget per blanking interval.
REQ-004 SHALL have port Clk  in  1: the single clock; Reset is asynchronous and active-high.
REQ-005 SHALL have port Reset  in  1: asynchronous active-high reset.
REQ-006 SHALL have port blank  in  1: high during the blanking interval; writes are allowed only then.
REQ-007 SHALL have port gameState  in  2: START=00, PLAY=01, GAMEOVER=10.
REQ-008 SHALL have port req  in  NUM_REQ: per-requester write request.
REQ-009 SHALL have port req_addr  in  NUM_REQ*ADDR_W: packed per-requester addresses, requester 0 in the LSBs.
REQ-010 SHALL have port req_pixel  in  NUM_REQ*5: packed per-requester 5-bit encoded pixels.
REQ-011 SHALL have port gnt  out  NUM_REQ: one-hot, one-cycle acknowledge.
REQ-012 SHALL have ports ram_we  out  1, ram_addr  out  ADDR_W, ram_data  out  5: frame RAM write port.
REQ-013 SHALL have port busy  out  1: high while in state GRANT.

Function
REQ-014 SHALL implement the FSM states IDLE, GRANT and EXHAUSTED.
REQ-015 SHALL go IDLE->GRANT on the rising edge of blank, clearing the write counter.
REQ-016 SHALL go GRANT->IDLE and EXHAUSTED->IDLE in the cycle after blank is sampled low.
REQ-017 SHALL go GRANT->EXHAUSTED when the grant counter reaches MAX_WRITES.
REQ-018 SHALL, in GRANT with any req high, select one winner per cycle, with at most one gnt bit high.
REQ-019 SHALL assert gnt and drive ram_addr/ram_data from the winner's fields, registered, one cycle after the request is sampled.
REQ-020 SHALL, by default, use round-robin arbitration: the pointer moves to winner+1 modulo NUM_REQ; with all requesters active, grants go 0,1,2,3,0...
REQ-021 SHALL assert ram_we together with gnt, except when the pixel is 5'h15 (transparent) or gameState is not PLAY; in those cases gnt pulses and ram_we stays 0.
REQ-022 SHALL count every grant, transparent or not, against MAX_WRITES; the counter saturates and never wraps.
REQ-023 SHALL issue no grant in IDLE or EXHAUSTED; requesters hold req, addr and pixel stable until gnt.
REQ-024 SHALL complete an already-registered write when blank falls mid-burst, and issue no new grant.
REQ-025 SHALL ignore requests in the cycle a requester is granted; that requester is eligible again from the next cycle.

Reset
REQ-026 SHALL, on Reset, asynchronously force: state IDLE, pointer 0, counter 0, gnt 0, ram_we 0, ram_addr 0, ram_data 0, busy 0.
REQ-027 SHALL, on Reset during GRANT, drop any pending write with no grant; after release, wait for the next rising edge of blank.

Configuration
REQ-028 SHALL, with macro FRAME_ARB_FIXED_PRIO_EN defined, use fixed priority where the lowest index wins and the pointer is unused.
REQ-029 SHALL, without FRAME_ARB_FIXED_PRIO_EN, use the round-robin arbitration of REQ-020.

Structure
REQ-030 SHALL place the FSM state enum, the gameState constants START/PLAY/GAMEOVER and TRANSPARENT_PIX=5'h15 in package frame_arb_pkg.
REQ-031 SHALL implement winner selection (round-robin or fixed) in sub-module rr_arbiter, with pointer state local to it.

Verification
REQ-032 SHALL cover: PLAY, blank rises, req=4'b1111 held -> gnt 0001,0010,0100,1000,0001 on consecutive cycles, ram_we=1 each.
REQ-033 SHALL cover: req0 pixel 5'h15, addr 100 -> gnt[0] pulses, ram_we=0.
REQ-034 SHALL cover: gameState=START, req1 pixel 5'h03 -> gnt[1] pulses, ram_we=0.
REQ-035 SHALL cover: MAX_WRITES=3, four requests -> three grants, state EXHAUSTED, fourth granted only in the next blank.
REQ-036 SHALL cover: blank falls one cycle after a grant decision -> that write completes (ram_we=1 once), then busy=0 and no gnt.
REQ-037 SHALL cover: Reset asserted mid-GRANT -> all outputs 0 immediately without a clock edge; with FRAME_ARB_FIXED_PRIO_EN defined, req=4'b1010 -> gnt[1] repeatedly.

Source files
------------

// File: rtl/frame_arb_pkg.sv
// Shared FSM state type, game-state encodings and pixel constants for frame_write_arbiter.
package frame_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        EXHAUSTED = 2'd2
    } arb_state_e;

    localparam logic [1:0] START    = 2'b00;
    localparam logic [1:0] PLAY     = 2'b01;
    localparam logic [1:0] GAMEOVER = 2'b10;

    localparam logic [4:0] TRANSPARENT_PIX = 5'h15;

endpackage

// File: rtl/frame_write_arbiter_rr_arbiter.sv
// Winner selection for frame_write_arbiter: round-robin by default, fixed lowest-index
// priority when FRAME_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
    import frame_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic               win_valid
);

`ifdef FRAME_ARB_FIXED_PRIO_EN

    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, advance};

    // Scan from the top down so the lowest requesting index is the last one written.
    always_comb begin
        win_onehot = '0;
        win_valid  = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
                win_valid     = 1'b1;
            end
        end
    end

`else

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   sum;

    // Search starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        win_onehot = '0;
        win_valid  = 1'b0;
        win_idx    = '0;
        idx        = '0;
        sum        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            idx = sum[IDX_W-1:0];
            if (!win_valid && req[idx]) begin
                win_valid       = 1'b1;
                win_onehot[idx] = 1'b1;
                win_idx         = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && win_valid) begin
            ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/frame_write_arbiter.sv
// Arbitrates pixel writes from NUM_REQ requesters into the frame RAM during blanking.
// Define FRAME_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module frame_write_arbiter
    import frame_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 19,
    parameter int MAX_WRITES = 1024
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      blank,
    input  logic [1:0]                gameState,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*5-1:0]      req_pixel,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [4:0]                ram_data,
    output logic                      busy
);

    localparam int CNT_W = $clog2(MAX_WRITES + 1);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WRITES);

    arb_state_e state_q, state_d;

    logic               blank_prev_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [4:0]         ram_data_q, ram_data_d;

    logic               blank_rise;
    logic               budget_left;
    logic               grant_allowed;
    logic               grant_fire;
    logic [NUM_REQ-1:0] req_eligible;
    logic [NUM_REQ-1:0] win_onehot;
    logic               win_valid;
    logic [ADDR_W-1:0]  win_addr;
    logic [4:0]         win_pixel;

    assign blank_rise    = blank && !blank_prev_q;
    assign budget_left   = (count_q < MAX_CNT);
    assign grant_allowed = (state_q == GRANT) && blank && budget_left;
    // A requester still shows req in the cycle its gnt is out; skip it for that cycle.
    assign req_eligible  = req & ~gnt_q;
    assign grant_fire    = grant_allowed && win_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .clk        (Clk),
        .rst        (Reset),
        .req        (req_eligible),
        .advance    (grant_allowed),
        .win_onehot (win_onehot),
        .win_valid  (win_valid)
    );

    always_comb begin
        win_addr  = '0;
        win_pixel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_pixel = req_pixel[i*5 +: 5];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (state_q == IDLE && blank_rise) begin
            count_d = '0;
        end else if (grant_fire) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (blank_rise) state_d = GRANT;
            GRANT: begin
                if (!blank) begin
                    state_d = IDLE;
                end else if (count_d == MAX_CNT) begin
                    state_d = EXHAUSTED;
                end
            end
            EXHAUSTED: if (!blank) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == GRANT);
    end

    always_comb begin
        gnt_d      = '0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        if (grant_fire) begin
            gnt_d      = win_onehot;
            ram_we_d   = (win_pixel != TRANSPARENT_PIX) && (gameState == PLAY);
            ram_addr_d = win_addr;
            ram_data_d = win_pixel;
        end
    end

    // blank_prev resets high so a blank already high at reset release is not an edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            blank_prev_q <= 1'b1;
            count_q      <= '0;
            gnt_q        <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
        end else begin
            blank_prev_q <= blank;
            count_q      <= count_d;
            gnt_q        <= gnt_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
        end
    end

    assign gnt      = gnt_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;

endmodule
